window_valid_gen: RTL and testbench

WINDOW_VALID_GEN -- requirements
Module: window_valid_gen

---
 rtl/window_valid_gen.sv | 115 +++++++++++
 tb/tb_window_valid_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/window_valid_gen.sv
// Tracks pixel position inside a frame and produces a delayed window-enable flag
// that marks pixels whose square window lies fully inside the image.
module window_valid_gen #(
    parameter int IMG_W    = 100,
    parameter int IMG_H    = 100,
    parameter int WIN      = 3,
    parameter int PIPE_DLY = 2,
    parameter int CNT_W    = 19,
    localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             pix_valid,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [CNT_W-1:0] pix_count,
    output logic             win_ok,
    output logic             frame_done,
    output logic             overrun
);
    // state  | meaning
    // IDLE   | waiting for frame_start, pixels ignored
    // ACTIVE | accepting pixels of the current frame
    // DONE   | frame complete, counters frozen, extra pixels flag overrun
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_t           state, state_nxt;
    logic [COL_W-1:0] col_nxt, pos_col;
    logic [ROW_W-1:0] row_nxt, pos_row;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept, last, raw, done_nxt, ovr_nxt;
    logic [PIPE_DLY+1:0] dly;

    // Position the next accepted pixel would take; a zero count means the frame has no pixel yet.
    always_comb begin
        pos_col = '0;
        pos_row = '0;
        if (!frame_start && pix_count != '0) begin
            if (col == COL_LAST) begin
                pos_row = (row == ROW_LAST) ? row : row + ROW_W'(1);
            end else begin
                pos_col = col + COL_W'(1);
                pos_row = row;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        cnt_nxt   = pix_count;
        ovr_nxt   = overrun;
        accept    = 1'b0;
        if (frame_start) begin
            state_nxt = ACTIVE;
            col_nxt   = '0;
            row_nxt   = '0;
            cnt_nxt   = '0;
            ovr_nxt   = 1'b0;
            accept    = pix_valid;
        end else begin
            case (state)
                ACTIVE:  accept = pix_valid;
                DONE:    if (pix_valid) ovr_nxt = 1'b1;
                default: ;
            endcase
        end
        last = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
        if (accept) begin
            col_nxt = pos_col;
            row_nxt = pos_row;
            cnt_nxt = frame_start ? CNT_W'(1) : pix_count + CNT_W'(1);
            if (last) state_nxt = DONE;
        end
        done_nxt = accept && last;
        raw = accept && (32'(pos_row) + 32'd1 >= 32'(WIN))
                     && (32'(pos_col) + 32'd1 >= 32'(WIN));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The delay line shifts unconditionally so in-flight flags survive restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col        <= '0;
            row        <= '0;
            pix_count  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            dly        <= '0;
        end else begin
            col        <= col_nxt;
            row        <= row_nxt;
            pix_count  <= cnt_nxt;
            frame_done <= done_nxt;
            overrun    <= ovr_nxt;
            dly        <= {dly[PIPE_DLY:0], raw};
        end
    end

    assign win_ok = dly[PIPE_DLY+1];

endmodule

// File: tb/tb_window_valid_gen.sv
// Directed bench for window_valid_gen: behavioural frame model plus a queue
// holding expected win_ok values in flight through the delay line.
module tb_window_valid_gen;
    localparam int IW = 100;
    localparam int IH = 100;
    localparam int WN = 3;
    localparam int PD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fs = 1'b0, pv = 1'b0;
    logic [6:0]  col, row;
    logic [18:0] cnt;
    logic        win, done, ovr;

    logic        fs_b = 1'b0, pv_b = 1'b0;
    logic [2:0]  col_b;
    logic [1:0]  row_b;
    logic [18:0] cnt_b;
    logic        win_b, done_b, ovr_b;

    window_valid_gen dut (
        .clk(clk), .reset(reset), .frame_start(fs), .pix_valid(pv),
        .col(col), .row(row), .pix_count(cnt),
        .win_ok(win), .frame_done(done), .overrun(ovr)
    );

    window_valid_gen #(.IMG_W(8), .IMG_H(4), .WIN(1), .PIPE_DLY(0)) dut_b (
        .clk(clk), .reset(reset), .frame_start(fs_b), .pix_valid(pv_b),
        .col(col_b), .row(row_b), .pix_count(cnt_b),
        .win_ok(win_b), .frame_done(done_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int m_state, m_cnt;
    bit m_ovr, m_done;
    bit wq[$];
    int step_no, first_win, win_seen;

    task automatic chk(string tag, int obs, int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_ovr   = 0;
        m_done  = 0;
        wq.delete();
        for (int i = 0; i < PD + 1; i++) wq.push_back(1'b0);
    endtask

    task automatic step(bit f, bit v);
        bit acc, raw, exp_win;
        @(negedge clk);
        fs = f;
        pv = v;
        acc = 0;
        raw = 0;
        m_done = 0;
        if (f) begin
            m_state = 1;
            m_cnt   = 0;
            m_ovr   = 0;
            acc     = v;
        end else if (m_state == 1 && v) begin
            acc = 1;
        end else if (m_state == 2 && v) begin
            m_ovr = 1;
        end
        if (acc) begin
            m_cnt++;
            raw = ((m_cnt - 1) / IW >= WN - 1) && ((m_cnt - 1) % IW >= WN - 1);
            if (m_cnt == IW * IH) begin
                m_state = 2;
                m_done  = 1;
            end
        end
        wq.push_back(raw);
        @(posedge clk);
        #1;
        exp_win = wq.pop_front();
        chk("col", int'(col), (m_cnt == 0) ? 0 : (m_cnt - 1) % IW);
        chk("row", int'(row), (m_cnt == 0) ? 0 : (m_cnt - 1) / IW);
        chk("pix_count", int'(cnt), m_cnt);
        chk("frame_done", int'(done), int'(m_done));
        chk("overrun", int'(ovr), int'(m_ovr));
        chk("win_ok", int'(win), int'(exp_win));
        if (win) begin
            win_seen++;
            if (first_win < 0) first_win = step_no;
        end
        step_no++;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_col"}, int'(col), 0);
        chk({tag, "_row"}, int'(row), 0);
        chk({tag, "_cnt"}, int'(cnt), 0);
        chk({tag, "_win"}, int'(win), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ovr"}, int'(ovr), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        model_reset();
        #2 reset = 1'b0;
        #1 check_all_zero("reset");
        chk("reset_b_cnt", int'(cnt_b), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle: pixels ignored until frame_start
        repeat (3) step(0, 1);

        // Small configuration: WIN=1, no extra pipeline
        fs_b = 1'b1;
        step(0, 0);
        fs_b = 1'b0;
        chk("b_start_cnt", int'(cnt_b), 0);
        for (int s = 0; s < 32; s++) begin
            pv_b = 1'b1;
            step(0, 0);
            chk("b_cnt", int'(cnt_b), s + 1);
            chk("b_col", int'(col_b), s % 8);
            chk("b_row", int'(row_b), s / 8);
            chk("b_win", int'(win_b), (s >= 1) ? 1 : 0);
            chk("b_done", int'(done_b), (s == 31) ? 1 : 0);
        end
        pv_b = 1'b0;
        step(0, 0);
        chk("b_win_last", int'(win_b), 1);
        chk("b_done_after", int'(done_b), 0);
        step(0, 0);
        chk("b_win_drained", int'(win_b), 0);

        // Full frame of back-to-back pixels
        step(1, 0);
        step_no = 0;
        first_win = -1;
        repeat (IW * IH) step(0, 1);
        chk("first_win_step", first_win, 202 + PD + 1);
        chk("full_frame_cnt", int'(cnt), IW * IH);

        // Overrun after completion, then cleared by restart
        repeat (3) step(0, 1);
        chk("overrun_set", int'(ovr), 1);
        chk("overrun_cnt", int'(cnt), IW * IH);
        step(1, 0);
        chk("overrun_cleared", int'(ovr), 0);

        // Random 50% pixel valid over a whole frame
        win_seen = 0;
        guard = 0;
        while (m_state != 2 && guard < 30000) begin
            step(0, 1'($urandom_range(0, 1)));
            guard++;
        end
        chk("random_frame_complete", m_state, 2);
        repeat (PD + 2) step(0, 0);
        chk("random_win_count", win_seen, 98 * 98);

        // Restart with a pixel mid-frame at index 500
        step(1, 0);
        repeat (500) step(0, 1);
        step(1, 1);
        chk("restart_cnt", int'(cnt), 1);
        repeat (5) step(0, 1);

        // Asynchronous reset mid-frame at pixel 5000
        guard = 0;
        while (m_cnt < 5000 && guard < 6000) begin
            step(0, 1);
            guard++;
        end
        chk("reached_5000", int'(cnt), 5000);
        @(negedge clk);
        reset = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step(0, 1);
        chk("after_reset_ignored", int'(cnt), 0);
        step(1, 1);
        repeat (6) step(0, 1);
        chk("after_reset_frame", int'(cnt), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
